pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the instruction memory.
- Holds the PC register, drives the word address into instruction memory every cycle, and computes next-PC from sequential, branch, jump and jump-register redirects.
- Adds stall, halt and address-fault handling through a small run-state machine, plus a retired-fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in words; valid byte addresses are 0 to IMEM_WORDS*4-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- halt_req  in  1  request to stop fetching (end of program).
- branch_taken  in  1  conditional branch resolved taken.
- branch_imm  in  16  raw branch immediate (word offset).
- jump  in  1  J/JAL redirect.
- jump_target  in  26  instr_index field.
- jump_reg  in  1  JR redirect.
- jr_addr  in  32  register-sourced target.
- pc  out  32  current PC; connects to instruction memory address.
- pc_plus4  out  32  pc + 4 (for JAL link and branch base).
- halted  out  1  high in HALT state.
- fault  out  1  high in FAULT state.
- fetch_count  out  32  number of PC advances since reset.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, halted=0, fault=0, fetch_count=0, state=RUN.
- pc_plus4: combinational pc+4, 32-bit, wraps modulo 2^32.
- Branch target: pc_plus4 + (sign_extend(branch_imm) << 2), 32-bit modulo.
- Jump target: {pc_plus4[31:28], jump_target, 2'b00}.
- Next-PC priority: jump_reg > jump > branch_taken > pc_plus4. This priority resolves simultaneous redirects.
- States:
  - RUN -> HALT when halt_req=1 (checked first). PC does not update on that edge.
  - RUN, stall=1, halt_req=0: PC and fetch_count hold.
  - RUN, stall=0, halt_req=0: compute next.
    - If next[1:0]!=0 or next >= IMEM_WORDS*4: -> FAULT; PC holds; fetch_count holds.
    - Otherwise: pc<=next and fetch_count<=fetch_count+1 (saturates at 32'hFFFF_FFFF).
  - HALT: all inputs ignored. PC frozen; halted=1. Exit only by reset.
  - FAULT: all inputs ignored. PC frozen at the last valid value; fault=1. Exit only by reset.
- halted and fault are registered. They assert on the edge that enters the state and are never both high.
- Latency: a redirect presented in cycle N appears on pc after the rising edge ending cycle N (single-cycle datapath, no delay slot).
- Reset mid-operation: asserting reset in any state forces the reset values immediately, without waiting for a clock. Fetch restarts from RESET_PC on the first edge after deassertion.
- Misaligned branch/jump targets cannot occur by construction; only jr_addr and range overflow can fault.
- pc_plus4 overflow past the last word (e.g. pc = IMEM_WORDS*4-4) faults rather than wrapping.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN.
- Defined:
  - Adds outputs branch_count[15:0] and jump_count[15:0], reset to 0.
  - branch_count increments on each accepted PC update where branch_taken was the winning source.
  - jump_count increments on each accepted PC update where jump or jump_reg won.
  - Both counters are saturating and hold during stall, HALT and FAULT.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset then 5 free-running cycles -> pc sequence 0,4,8,12,16,20; fetch_count=5; halted=0, fault=0.
- At pc=0x20: branch_taken=1, branch_imm=16'hFFFC -> pc=0x14. At pc=0x14: branch_imm=16'h0003 -> pc=0x24.
- Priority: at pc=0x10, assert jump_reg=1 with jr_addr=0x40, jump=1 with jump_target=0x10, and branch_taken=1, all in the same cycle -> pc=0x40.
- Jump: at pc=0x40, jump=1, jump_target=26'h0000010 -> pc=0x40.
- Stall for 3 cycles at pc=0x8 -> pc stays 0x8 and fetch_count unchanged; release -> pc=0xC.
- Fault cases:
  - jump_reg=1, jr_addr=0x42 -> fault=1, pc holds, later inputs ignored.
  - jr_addr=0x1000 with IMEM_WORDS=1024 -> fault=1.
- Halt and reset: halt_req=1 at pc=0x18 -> halted=1, pc stays 0x18 for 10 cycles; async reset pulse between clock edges -> pc=0 immediately, halted=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter stage feeding instruction memory: next-PC selection, run/halt/fault
// state machine and a saturating fetch counter. Optional redirect statistics under PC_REDIRECT_STATS_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [15:0] branch_count,
  output logic [15:0] jump_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Widened by one bit so a full 4 GiB address map still compares correctly.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic        r_halted;
  logic        r_fault;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_next_pc;
  logic        w_next_bad;
  logic        w_advance;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = w_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign w_jump_target   = {w_pc_plus4[31:28], jump_target, 2'b00};

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump_reg)          w_next_pc = jr_addr;
    else if (jump)         w_next_pc = w_jump_target;
    else if (branch_taken) w_next_pc = w_branch_target;
  end

  // Running off the end of memory faults instead of wrapping back to zero.
  assign w_next_bad = (w_next_pc[1:0] != 2'b00) || ({1'b0, w_next_pc} >= IMEM_BYTES);

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt_req) begin
          w_state_next = ST_HALT;
        end else if (!stall) begin
          if (w_next_bad) w_state_next = ST_FAULT;
          else            w_advance    = 1'b1;
        end
      end
      ST_HALT:  w_state_next = ST_HALT;
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_FAULT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'd0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_halted <= (w_state_next == ST_HALT);
      r_fault  <= (w_state_next == ST_FAULT);
      if (w_advance) begin
        r_pc <= w_next_pc;
        if (r_fetch_count != 32'hFFFF_FFFF) r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] r_branch_count;
  logic [15:0] r_jump_count;
  logic        w_branch_won;
  logic        w_jump_won;

  assign w_branch_won = branch_taken && !jump && !jump_reg;
  assign w_jump_won   = jump || jump_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_branch_count <= 16'd0;
      r_jump_count   <= 16'd0;
    end else if (w_advance) begin
      if (w_branch_won && r_branch_count != 16'hFFFF) r_branch_count <= r_branch_count + 16'd1;
      if (w_jump_won && r_jump_count != 16'hFFFF)     r_jump_count   <= r_jump_count + 16'd1;
    end
  end

  assign branch_count = r_branch_count;
  assign jump_count   = r_jump_count;
`endif

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit plus hand sequences for halt, fault and async reset.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        halt_req;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;
`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] branch_count;
  logic [15:0] jump_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .jump_reg     (jump_reg),
    .jr_addr      (jr_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .fault        (fault),
    .fetch_count  (fetch_count)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .branch_count (branch_count),
    .jump_count   (jump_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        halt_req;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] jr_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_halted;
    logic        exp_fault;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic st, input logic hr, input logic bt,
                              input logic [15:0] bi, input logic j, input logic [25:0] jt,
                              input logic jr, input logic [31:0] ja, input logic [31:0] ep,
                              input logic [31:0] ec, input logic eh, input logic ef);
    vec_t v;
    v.stall = st; v.halt_req = hr; v.branch_taken = bt; v.branch_imm = bi;
    v.jump = j; v.jump_target = jt; v.jump_reg = jr; v.jr_addr = ja;
    v.exp_pc = ep; v.exp_cnt = ec; v.exp_halted = eh; v.exp_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic hr, input logic bt, input logic [15:0] bi,
                       input logic j, input logic [25:0] jt, input logic jr, input logic [31:0] ja);
    stall = st; halt_req = hr; branch_taken = bt; branch_imm = bi;
    jump = j; jump_target = jt; jump_reg = jr; jr_addr = ja;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Pulse reset between clock edges (called at posedge+1) and check the immediate effect.
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1;
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " halted"}, {31'h0, halted}, 32'h0);
    check({tag, " fault"}, {31'h0, fault}, 32'h0);
    check({tag, " count"}, fetch_count, 32'h0);
    idle();
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'(4 * (i + 1)), 32'(i + 1), 0, 0);
    vecs[8]  = mk(0, 0, 1, 16'hFFFC, 0, 26'h0,   0, 32'h0,  32'h14,  32'd9,  0, 0);
    vecs[9]  = mk(0, 0, 1, 16'h0003, 0, 26'h0,   0, 32'h0,  32'h24,  32'd10, 0, 0);
    vecs[10] = mk(0, 0, 0, 16'h0,    0, 26'h0,   1, 32'h10, 32'h10,  32'd11, 0, 0);
    vecs[11] = mk(0, 0, 1, 16'h0003, 1, 26'h10,  1, 32'h40, 32'h40,  32'd12, 0, 0);
    vecs[12] = mk(0, 0, 0, 16'h0,    1, 26'h10,  0, 32'h0,  32'h40,  32'd13, 0, 0);
    vecs[13] = mk(0, 0, 0, 16'h0,    0, 26'h0,   1, 32'h8,  32'h8,   32'd14, 0, 0);
    vecs[14] = mk(1, 0, 0, 16'h0,    0, 26'h0,   0, 32'h0,  32'h8,   32'd14, 0, 0);
    vecs[15] = mk(1, 0, 1, 16'h0005, 0, 26'h0,   0, 32'h0,  32'h8,   32'd14, 0, 0);
    vecs[16] = mk(1, 0, 0, 16'h0,    0, 26'h0,   1, 32'h42, 32'h8,   32'd14, 0, 0);
    vecs[17] = mk(0, 0, 0, 16'h0,    0, 26'h0,   0, 32'h0,  32'hC,   32'd15, 0, 0);
    vecs[18] = mk(0, 0, 0, 16'h0,    1, 26'h3FF, 0, 32'h0,  32'hFFC, 32'd16, 0, 0);
    vecs[19] = mk(0, 0, 0, 16'h0,    0, 26'h0,   0, 32'h0,  32'hFFC, 32'd16, 0, 1);
    vecs[20] = mk(0, 1, 0, 16'h0,    0, 26'h0,   1, 32'h0,  32'hFFC, 32'd16, 0, 1);

    reset = 1'b1;
    idle();
    #12 reset = 1'b0;
    #1;
    check("reset pc", pc, 32'h0);
    check("reset pc_plus4", pc_plus4, 32'h4);
    check("reset count", fetch_count, 32'h0);
    check("reset halted", {31'h0, halted}, 32'h0);
    check("reset fault", {31'h0, fault}, 32'h0);
`ifdef PC_REDIRECT_STATS_EN
    check("reset branch_count", {16'h0, branch_count}, 32'h0);
    check("reset jump_count", {16'h0, jump_count}, 32'h0);
`endif

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].stall, vecs[i].halt_req, vecs[i].branch_taken, vecs[i].branch_imm,
            vecs[i].jump, vecs[i].jump_target, vecs[i].jump_reg, vecs[i].jr_addr);
      cycle();
      check($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d pc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      check($sformatf("v%0d count", i), fetch_count, vecs[i].exp_cnt);
      check($sformatf("v%0d halted", i), {31'h0, halted}, {31'h0, vecs[i].exp_halted});
      check($sformatf("v%0d fault", i), {31'h0, fault}, {31'h0, vecs[i].exp_fault});
    end
`ifdef PC_REDIRECT_STATS_EN
    check("stats branch_count", {16'h0, branch_count}, 32'd2);
    check("stats jump_count", {16'h0, jump_count}, 32'd5);
`endif

    // Leave FAULT by reset, then halt at 0x18 (halt wins over a simultaneous stall).
    async_reset("rst from fault");
    drive(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h18);
    cycle();
    check("halt setup pc", pc, 32'h18);
    drive(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    cycle();
    check("halt pc", pc, 32'h18);
    check("halt halted", {31'h0, halted}, 32'h1);
    check("halt fault", {31'h0, fault}, 32'h0);
    check("halt count", fetch_count, 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 16'h0010, (i % 2) == 0, 26'h20, (i % 3) == 0, 32'h80);
      cycle();
      check($sformatf("halt hold%0d pc", i), pc, 32'h18);
      check($sformatf("halt hold%0d halted", i), {31'h0, halted}, 32'h1);
    end
    check("halt hold count", fetch_count, 32'd1);

    async_reset("rst from halt");
    cycle();
    check("restart pc", pc, 32'h4);
    check("restart count", fetch_count, 32'd1);
    check("restart halted", {31'h0, halted}, 32'h0);

    // Misaligned register target faults; later redirects are ignored.
    drive(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h42);
    cycle();
    check("misalign fault", {31'h0, fault}, 32'h1);
    check("misalign pc", pc, 32'h4);
    check("misalign count", fetch_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h100);
      cycle();
      check($sformatf("fault hold%0d pc", i), pc, 32'h4);
      check($sformatf("fault hold%0d fault", i), {31'h0, fault}, 32'h1);
    end

    // Target exactly one past the last word is out of range.
    async_reset("rst from fault2");
    drive(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h1000);
    cycle();
    check("range fault", {31'h0, fault}, 32'h1);
    check("range pc", pc, 32'h0);
    check("range count", fetch_count, 32'd0);
    check("range halted", {31'h0, halted}, 32'h0);

    // halt_req is examined before the fault check.
    async_reset("rst before halt-vs-fault");
    drive(0, 1, 0, 16'h0, 0, 26'h0, 1, 32'h42);
    cycle();
    check("halt over fault halted", {31'h0, halted}, 32'h1);
    check("halt over fault fault", {31'h0, fault}, 32'h0);
    check("halt over fault pc", pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
